// File: rtl/mux_valid_pkg.sv
// ----------------------------------------------------------------------------
// mux_valid_pkg
// Shared definitions for the 2:1 4-bit mux-with-valid datapath and the
// stages that sit downstream of it.
//   DATA_W      : word width produced by the mux
//   FIFO_DEPTH  : default buffer depth for downstream FIFOs
//   ptr_t/cnt_t : pointer and occupancy types sized for FIFO_DEPTH
//   ptr_width() : pointer width for an arbitrary depth (never below 1 bit)
// ----------------------------------------------------------------------------
package mux_valid_pkg;

    localparam int DATA_W     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = (FIFO_DEPTH <= 1) ? 1 : $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    function automatic int ptr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem_4b.sv
// ----------------------------------------------------------------------------
// fifo_mem_4b
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
// Ports:
//   i_clk      : write clock
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_addr  : read address
//   o_rd_data  : read data (combinational from i_rd_addr)
// ----------------------------------------------------------------------------
module fifo_mem_4b
    import mux_valid_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int AW         = ptr_width(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_valid_4b.sv
// ----------------------------------------------------------------------------
// fifo_valid_4b
// Synchronous FIFO that absorbs the out/out_valid stream of the 2:1 4-bit
// mux. The mux cannot be stalled, so every valid word is captured while
// space remains; a consumer drains words with pop. All outputs are
// registered.
// Ports:
//   clk           : clock, rising edge
//   reset         : asynchronous reset, active low
//   in/in_valid   : write data and strobe from the mux
//   pop           : consumer read request
//   out/out_valid : popped word, valid for the single cycle after a pop
//   count         : occupancy 0..DEPTH
//   full/empty/almost_full/almost_empty : occupancy flags
//   overflow_err  : sticky, a push was dropped
//   underflow_err : sticky, a pop arrived while empty
// ----------------------------------------------------------------------------
module fifo_valid_4b
    import mux_valid_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int AF_THRESH  = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            in,
    input  logic                             in_valid,
    input  logic                             pop,
    output logic [DATA_WIDTH-1:0]            out,
    output logic                             out_valid,
    output logic [ptr_width(DEPTH):0]        count,
    output logic                             full,
    output logic                             empty,
    output logic                             almost_full,
    output logic                             almost_empty,
    output logic                             overflow_err,
    output logic                             underflow_err
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_out_valid;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_overflow_err;
    logic                  r_underflow_err;

    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic [CW-1:0]         w_count_nxt;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // A pop only needs a stored word. A push needs a free slot, or a slot
    // being vacated by a pop on the same edge (only possible when not empty,
    // so an empty FIFO never bypasses the pushed word to the output).
    assign w_pop_ok    = pop && !r_empty;
    assign w_push_ok   = in_valid && (!r_full || w_pop_ok);
    assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop_ok);

    fifo_mem_4b #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_mem (
        .i_clk     (clk),
        .i_wr_en   (w_push_ok),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_out           <= '0;
            r_out_valid     <= 1'b0;
            r_full          <= 1'b0;
            r_empty         <= 1'b1;
            r_almost_full   <= 1'b0;
            r_almost_empty  <= 1'b1;
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            // The read port is combinational, so a simultaneous push into the
            // same slot (full case) cannot disturb the word being popped.
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_out    <= w_rd_data;
            end
            r_out_valid    <= w_pop_ok;
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == DEPTH_C);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= AF_C);
            r_almost_empty <= (w_count_nxt <= AE_C);
            if (in_valid && !w_push_ok) begin
                r_overflow_err <= 1'b1;
            end
            if (pop && r_empty) begin
                r_underflow_err <= 1'b1;
            end
        end
    end

    assign out           = r_out;
    assign out_valid     = r_out_valid;
    assign count         = r_count;
    assign full          = r_full;
    assign empty         = r_empty;
    assign almost_full   = r_almost_full;
    assign almost_empty  = r_almost_empty;
    assign overflow_err  = r_overflow_err;
    assign underflow_err = r_underflow_err;

endmodule

// File: tb/tb_fifo_valid_4b.sv
// ----------------------------------------------------------------------------
// tb_fifo_valid_4b
// Directed, table-driven bench for fifo_valid_4b (DEPTH=4, AF=3, AE=1).
// Each vector is driven on the falling edge, clocked on the next rising
// edge and checked on the following falling edge.
// ----------------------------------------------------------------------------
module tb_fifo_valid_4b;

    logic       clk;
    logic       rst_n;
    logic [3:0] din;
    logic       din_valid;
    logic       pop;
    logic [3:0] dout;
    logic       dout_valid;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow_err;
    logic       underflow_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] d;
        logic       v;
        logic       p;
        logic [3:0] exp_out;
        logic       exp_ov;
        int         exp_cnt;
        logic       exp_ovf;
        logic       exp_udf;
    } vec_t;

    vec_t vecs[$];

    fifo_valid_4b dut (
        .clk           (clk),
        .reset         (rst_n),
        .in            (din),
        .in_valid      (din_valid),
        .pop           (pop),
        .out           (dout),
        .out_valid     (dout_valid),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0d expected %0d", tag, nm, act, exp);
        end
    endtask

    // Flags are derived from the expected occupancy with the default thresholds.
    task automatic check_all(input string tag, input logic [3:0] e_out, input logic e_ov,
                             input int e_cnt, input logic e_ovf, input logic e_udf);
        chk(tag, "out",           int'(dout),          int'(e_out));
        chk(tag, "out_valid",     int'(dout_valid),    int'(e_ov));
        chk(tag, "count",         int'(count),         e_cnt);
        chk(tag, "full",          int'(full),          (e_cnt == 4) ? 1 : 0);
        chk(tag, "empty",         int'(empty),         (e_cnt == 0) ? 1 : 0);
        chk(tag, "almost_full",   int'(almost_full),   (e_cnt >= 3) ? 1 : 0);
        chk(tag, "almost_empty",  int'(almost_empty),  (e_cnt <= 1) ? 1 : 0);
        chk(tag, "overflow_err",  int'(overflow_err),  int'(e_ovf));
        chk(tag, "underflow_err", int'(underflow_err), int'(e_udf));
    endtask

    task automatic add(input logic [3:0] d, input logic v, input logic p,
                       input logic [3:0] eo, input logic eov, input int ec,
                       input logic eovf, input logic eudf);
        vec_t t;
        t.d = d; t.v = v; t.p = p;
        t.exp_out = eo; t.exp_ov = eov; t.exp_cnt = ec;
        t.exp_ovf = eovf; t.exp_udf = eudf;
        vecs.push_back(t);
    endtask

    task automatic step(input logic [3:0] d, input logic v, input logic p);
        din       = d;
        din_valid = v;
        pop       = p;
        @(negedge clk);
    endtask

    initial begin
        //   d     v  p   out  ov cnt ovf udf
        add(4'h1, 1, 0, 4'h0, 0, 1, 0, 0);   // fill
        add(4'h2, 1, 0, 4'h0, 0, 2, 0, 0);
        add(4'h3, 1, 0, 4'h0, 0, 3, 0, 0);   // almost_full
        add(4'h4, 1, 0, 4'h0, 0, 4, 0, 0);   // full
        add(4'hA, 1, 1, 4'h1, 1, 4, 0, 0);   // push+pop at full: accepted, no overflow
        add(4'h5, 1, 0, 4'h1, 0, 4, 1, 0);   // push at full: dropped
        add(4'h0, 0, 1, 4'h2, 1, 3, 1, 0);   // drain
        add(4'h0, 0, 1, 4'h3, 1, 2, 1, 0);
        add(4'h0, 0, 1, 4'h4, 1, 1, 1, 0);
        add(4'h0, 0, 1, 4'hA, 1, 0, 1, 0);   // 0xA comes out last
        add(4'h7, 1, 1, 4'hA, 0, 1, 1, 1);   // push+pop at empty: pop rejected
        add(4'h0, 0, 1, 4'h7, 1, 0, 1, 1);
        add(4'h0, 0, 0, 4'h7, 0, 0, 1, 1);   // idle: out holds, valid drops
        add(4'hE, 1, 0, 4'h7, 0, 1, 1, 1);   // preload to occupancy 2
        add(4'hF, 1, 0, 4'h7, 0, 2, 1, 1);
        for (int i = 0; i < 10; i++) begin
            add(4'(i), 1, 1, (i == 0) ? 4'hE : (i == 1) ? 4'hF : 4'(i - 2), 1, 2, 1, 1);
        end
        add(4'h0, 0, 1, 4'h8, 1, 1, 1, 1);
        add(4'h0, 0, 1, 4'h9, 1, 0, 1, 1);
        add(4'h0, 0, 1, 4'h9, 0, 0, 1, 1);   // pop at empty: no output

        // Reset defaults
        rst_n = 1'b0; din = '0; din_valid = 1'b0; pop = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("reset", 4'h0, 0, 0, 0, 0);

        foreach (vecs[k]) begin
            step(vecs[k].d, vecs[k].v, vecs[k].p);
            check_all($sformatf("vec%0d", k), vecs[k].exp_out, vecs[k].exp_ov,
                      vecs[k].exp_cnt, vecs[k].exp_ovf, vecs[k].exp_udf);
        end

        // Mid-operation asynchronous reset with three words stored
        step(4'h1, 1, 0);
        step(4'h2, 1, 0);
        step(4'h3, 1, 0);
        check_all("pre_rst", 4'h9, 0, 3, 1, 1);
        din_valid = 1'b0;
        pop       = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_all("mid_rst", 4'h0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_all("post_rst_pop", 4'h0, 0, 0, 0, 1);
        pop = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_valid_4b.md
# fifo_valid_4b

Small synchronous FIFO that sits directly downstream of the 2:1 4-bit mux with valid and absorbs its `out`/`out_valid` stream. The mux offers no backpressure, so this block captures every valid word, buffers up to DEPTH entries, and releases them on a consumer `pop`. Registered status flags let the consumer throttle itself, and sticky error flags record lost or invalid transfers.

## Interface
Parameters:
- `DATA_WIDTH`, 4, word width; must match the mux output width.
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `AF_THRESH`, 3, `almost_full` asserts when count ≥ AF_THRESH.
- `AE_THRESH`, 1, `almost_empty` asserts when count ≤ AE_THRESH.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `in`  in  DATA_WIDTH  write data, taken from the mux output.
- `in_valid`  in  1  write strobe, taken from the mux output valid.
- `pop`  in  1  consumer read request.
- `out`  out  DATA_WIDTH  registered read data.
- `out_valid`  out  1  `out` holds a freshly popped word this cycle.
- `count`  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  occupancy flags.
- `overflow_err`  out  1  sticky: a push was dropped.
- `underflow_err`  out  1  sticky: a pop arrived while empty.

## Operation
- **Reset** (`reset`=0, asynchronous): write pointer, read pointer and count clear to 0.
  - Reset values: `out`=0, `out_valid`=0, `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, both error flags 0.
  - Memory contents are not reset.
- **Push**: `in_valid`=1 and the FIFO is not full → write `in` at `wr_ptr`, then increment `wr_ptr` (wraps at DEPTH).
- **Pop**: `pop`=1 and the FIFO is not empty → `out` ← mem[`rd_ptr`], `out_valid` ← 1, then increment `rd_ptr` (wraps).
  - On any other cycle `out_valid` ← 0 and `out` holds its last value.
- **Count** updates by (push accepted) − (pop accepted).
- **Push and pop together while full**: both are accepted; count stays at DEPTH; no overflow is flagged.
- **Push and pop together while empty**: the push is stored and the pop is rejected; there is no bypass path.
  - `underflow_err` is set; count becomes 1.
- **Push while full with no pop**: the word is dropped, pointers do not move, `overflow_err` is set.
- **Pop while empty**: `underflow_err` is set and `out_valid` stays 0.
- **Error flags** are sticky. Only `reset` clears them.
- **Flag decode** from the next-state count:
  - `empty` = (count==0)
  - `full` = (count==DEPTH)
  - `almost_full` = (count ≥ AF_THRESH)
  - `almost_empty` = (count ≤ AE_THRESH)
- **Reset asserted mid-operation**: all stored words are discarded immediately; no partial pop completes.

## Timing
- Push-to-visible latency is 1 cycle: a word written at edge N can be popped at edge N+1. Its data appears on `out` after edge N+1.
- Pop-to-data latency is 1 cycle: `pop` sampled at edge N gives `out`/`out_valid` valid after edge N, for exactly one cycle.
- All flags and `count` are registered and reflect the state after the current edge. There are no combinational paths from input to output.
- Back-to-back pops sustain one word per cycle. Back-to-back pushes sustain one word per cycle.
- Pointer wrap: `DEPTH`−1 → 0 with no bubble.

## Structure
- Shared package `mux_valid_pkg` holds:
  - `DATA_W` = 4.
  - the default `FIFO_DEPTH` = 4.
  - a `ptr_t`/`cnt_t` width helper (clog2-based) for reuse by other downstream stages.
- Sub-module `fifo_mem_4b`: a DEPTH×DATA_WIDTH register array with a synchronous write port and an asynchronous read port, no reset.
- Pointer, count, flag and error logic live in the top level.

## Test plan
- **Reset defaults**: hold `reset`=0 for 2 cycles, then release → `empty`=1, `count`=0, `out_valid`=0, `out`=0, both errors 0.
- **Fill, overflow, drain**:
  - Push 0x1, 0x2, 0x3, 0x4 on consecutive cycles → `almost_full`=1 after the 3rd push, `full`=1 and `count`=4 after the 4th.
  - A 5th push of 0x5 → `overflow_err`=1, `count` stays 4.
  - Then pop 4 times → `out` = 0x1, 0x2, 0x3, 0x4 each with `out_valid`=1, ending with `empty`=1.
- **Simultaneous on full**: at `full`, push 0xA with `pop`=1 → `out`=oldest word, `count` stays 4, no overflow.
  - Draining afterwards shows 0xA last.
- **Simultaneous on empty**: from empty, push 0x7 with `pop`=1 → `underflow_err`=1, `out_valid`=0, `count`=1.
  - A pop on the next cycle returns 0x7.
- **Wrap-around**: run 10 push/pop pairs with data 0x0..0x9 at occupancy 2 → output order is preserved across two pointer wraps, `count` stays 2.
- **Mid-operation reset**: with `count`=3, assert `reset` asynchronously between edges → flags return to their reset values immediately; after release, the first pop sets `underflow_err`.
